// File: rtl/mpu_arb_pkg.sv
// Shared types and constants for the MPU encode-chain front-end arbiter.
package mpu_arb_pkg;

    // Information block length of the RS encoder (mirrors rs_encoder_pkg::RS_K)
    localparam int         RS_K              = 223;
    localparam int         FRAME_LEN_DEFAULT = RS_K;
    localparam logic [7:0] FILL_BYTE_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        PAD   = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mpu_frame_arbiter_rr_arbiter.sv
// Combinational N-way round-robin picker: first requester at or after ptr.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int pos;

    // Walk the request vector starting at ptr, wrapping, and keep the first hit
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/mpu_frame_arbiter.sv
// Frame-atomic round-robin front end for the MPU encode chain. Pads short
// messages to FRAME_LEN bytes, drops oversize tails and limits frames in
// flight with a credit counter returned by frame_done.
// Optional statistics counters are enabled by defining MPU_ARB_STATS_EN.
module mpu_frame_arbiter
    import mpu_arb_pkg::*;
#(
    parameter int         N_SRC        = 4,
    parameter int         FRAME_LEN    = FRAME_LEN_DEFAULT,
    parameter logic [7:0] FILL_BYTE    = FILL_BYTE_DEFAULT,
    parameter int         MAX_INFLIGHT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SRC-1:0]         s_axis_valid,
    output logic [N_SRC-1:0]         s_axis_ready,
    input  logic [8*N_SRC-1:0]       s_axis_data,
    input  logic [N_SRC-1:0]         s_axis_last,
    output logic                     m_axis_valid,
    input  logic                     m_axis_ready,
    output logic [7:0]               m_axis_data,
    output logic                     m_axis_last,
    input  logic                     frame_done,
    output logic [$clog2(N_SRC)-1:0] grant_id,
    output logic                     busy,
    output logic                     overrun
`ifdef MPU_ARB_STATS_EN
    ,
    output logic [31:0]              frames_sent,
    output logic [31:0]              pad_bytes
`endif
);

    localparam int                IDX_W      = $clog2(N_SRC);
    localparam int                CNT_W      = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(FRAME_LEN - 1);
    localparam logic [3:0]        MAX_CREDIT = 4'(MAX_INFLIGHT);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] ptr_after_pick;
    logic             found;
    logic [CNT_W-1:0] byte_cnt;
    logic [3:0]       inflight;
    logic             overrun_q;
    logic             grant_fire;
    logic             set_overrun;
    logic             at_last;
    logic             credit_ok;
    logic             done_take;
    logic             m_hs;
    logic             sel_valid;
    logic             sel_last;
    logic [7:0]       sel_data;

    rr_arbiter #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (s_axis_valid),
        .ptr   (rr_ptr),
        .idx   (pick),
        .found (found)
    );

    assign sel_valid      = s_axis_valid[grant_q];
    assign sel_last       = s_axis_last[grant_q];
    assign sel_data       = s_axis_data[8*grant_q +: 8];
    assign at_last        = (byte_cnt == LAST_CNT);
    assign credit_ok      = (inflight < MAX_CREDIT);
    assign done_take      = frame_done && (inflight != 4'd0);
    assign m_hs           = m_axis_valid && m_axis_ready;
    assign ptr_after_pick = (pick == IDX_W'(N_SRC - 1)) ? '0 : pick + 1'b1;

    // Registered status outputs are forced low while reset is held
    assign grant_id = rst ? '0 : grant_q;
    assign busy     = !rst && (state != IDLE);
    assign overrun  = !rst && overrun_q;

    // Next-state and datapath steering; the granted source owns the RS input for a whole frame
    always_comb begin
        state_next   = state;
        m_axis_valid = 1'b0;
        m_axis_data  = 8'h00;
        m_axis_last  = 1'b0;
        s_axis_ready = '0;
        grant_fire   = 1'b0;
        set_overrun  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (found && credit_ok) begin
                        grant_fire = 1'b1;
                        state_next = PASS;
                    end
                end
                PASS: begin
                    m_axis_valid          = sel_valid;
                    m_axis_data           = sel_data;
                    m_axis_last           = at_last;
                    s_axis_ready[grant_q] = m_axis_ready;
                    if (sel_valid && m_axis_ready) begin
                        if (at_last) begin
                            if (sel_last) begin
                                state_next = IDLE;
                            end else begin
                                set_overrun = 1'b1;
                                state_next  = DRAIN;
                            end
                        end else if (sel_last) begin
                            state_next = PAD;
                        end
                    end
                end
                PAD: begin
                    m_axis_valid = 1'b1;
                    m_axis_data  = FILL_BYTE;
                    m_axis_last  = at_last;
                    if (m_axis_ready && at_last) begin
                        state_next = IDLE;
                    end
                end
                DRAIN: begin
                    s_axis_ready[grant_q] = 1'b1;
                    if (sel_valid && sel_last) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State, grant bookkeeping, byte position, credits and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_q   <= '0;
            byte_cnt  <= '0;
            inflight  <= 4'd0;
            overrun_q <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_fire) begin
                grant_q  <= pick;
                rr_ptr   <= ptr_after_pick;
                byte_cnt <= '0;
            end else if (m_hs) begin
                byte_cnt <= byte_cnt + 1'b1;
            end
            case ({grant_fire, done_take})
                2'b10:   inflight <= inflight + 4'd1;
                2'b01:   inflight <= inflight - 4'd1;
                default: inflight <= inflight;
            endcase
            if (set_overrun) begin
                overrun_q <= 1'b1;
            end
        end
    end

`ifdef MPU_ARB_STATS_EN
    // Wrapping counters of emitted frames and inserted fill bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_sent <= '0;
            pad_bytes   <= '0;
        end else begin
            if (m_hs && m_axis_last) begin
                frames_sent <= frames_sent + 32'd1;
            end
            if (m_hs && (state == PAD)) begin
                pad_bytes <= pad_bytes + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mpu_frame_arbiter.sv
// Self-checking bench for mpu_frame_arbiter: queued sources, frame-level
// reference model and a scoreboard monitor on the RS-side stream.
module tb_mpu_frame_arbiter;

    localparam int         N_SRC        = 4;
    localparam int         FRAME_LEN    = 223;
    localparam int         MAX_INFLIGHT = 2;
    localparam logic [7:0] FILL         = 8'h00;
    localparam int         HALF         = 5;

    logic               clk;
    logic               rst;
    logic [N_SRC-1:0]   s_axis_valid;
    logic [N_SRC-1:0]   s_axis_ready;
    logic [8*N_SRC-1:0] s_axis_data;
    logic [N_SRC-1:0]   s_axis_last;
    logic               m_axis_valid;
    logic               m_axis_ready;
    logic [7:0]         m_axis_data;
    logic               m_axis_last;
    logic               frame_done;
    logic [1:0]         grant_id;
    logic               busy;
    logic               overrun;
`ifdef MPU_ARB_STATS_EN
    logic [31:0]        frames_sent;
    logic [31:0]        pad_bytes;
`endif

    mpu_frame_arbiter #(
        .N_SRC        (N_SRC),
        .FRAME_LEN    (FRAME_LEN),
        .FILL_BYTE    (FILL),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .s_axis_data  (s_axis_data),
        .s_axis_last  (s_axis_last),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_last  (m_axis_last),
        .frame_done   (frame_done),
        .grant_id     (grant_id),
        .busy         (busy),
        .overrun      (overrun)
`ifdef MPU_ARB_STATS_EN
        ,
        .frames_sent  (frames_sent),
        .pad_bytes    (pad_bytes)
`endif
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #HALF clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Source streams still to be offered ({last, data}) and the model's copy
    logic [8:0] src_q [N_SRC][$];
    logic [8:0] mdl_q [N_SRC][$];
    bit         started [N_SRC];

    // Scoreboard: per byte {pad, last, data}; per frame source and overrun-so-far
    logic [9:0] exp_q[$];
    int         exp_src_q[$];
    bit         exp_ovr_q[$];

    int mdl_rr         = 0;
    bit mdl_ovr        = 0;
    int out_cnt        = 0;
    int frames_started = 0;
    int mon_pos        = 0;
    int gap_pct        = 0;
    int mready_pct     = 100;
    int done_pct       = 0;
    bit done_en        = 0;
    bit force_done     = 0;
    bit rst_drv        = 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, account handshakes just before the rising edge
    task automatic applyStimulus();
        logic [8:0] e;
        @(negedge clk);
        rst = rst_drv;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_q[i].size() > 0) begin
                e = src_q[i][0];
                s_axis_valid[i]       = started[i] ? ($urandom_range(99) >= gap_pct) : 1'b1;
                s_axis_data[8*i +: 8] = e[7:0];
                s_axis_last[i]        = e[8];
            end else begin
                s_axis_valid[i]       = 1'b0;
                s_axis_data[8*i +: 8] = 8'h00;
                s_axis_last[i]        = 1'b0;
            end
        end
        m_axis_ready = ($urandom_range(99) < mready_pct);
        frame_done   = force_done || (done_en && (out_cnt > 0) && ($urandom_range(99) < done_pct));
        #(HALF - 1);
        if (frame_done && !rst) out_cnt--;
        for (int i = 0; i < N_SRC; i++) begin
            if (!rst && s_axis_valid[i] && s_axis_ready[i]) begin
                e = src_q[i].pop_front();
                started[i] = !e[8];
            end
        end
    endtask

    task automatic loadMsg(input int src, input int len, input bit seq);
        logic [7:0] d;
        for (int k = 0; k < len; k++) begin
            d = seq ? 8'(k + 1) : 8'($urandom_range(255));
            src_q[src].push_back({(k == len - 1), d});
            mdl_q[src].push_back({(k == len - 1), d});
        end
    endtask

    // Frame-level model: round-robin over sources holding messages, pad or truncate to FRAME_LEN
    task automatic commitBatch();
        int         pick;
        int         j;
        logic [8:0] e;
        logic [7:0] msg[$];
        while (1) begin
            pick = -1;
            for (int k = 0; k < N_SRC; k++) begin
                j = (mdl_rr + k) % N_SRC;
                if (pick < 0 && mdl_q[j].size() > 0) pick = j;
            end
            if (pick < 0) break;
            mdl_rr = (pick + 1) % N_SRC;
            msg.delete();
            do begin
                e = mdl_q[pick].pop_front();
                msg.push_back(e[7:0]);
            end while (!e[8]);
            exp_src_q.push_back(pick);
            exp_ovr_q.push_back(mdl_ovr);
            for (int k = 0; k < FRAME_LEN; k++) begin
                if (k < msg.size()) exp_q.push_back({1'b0, (k == FRAME_LEN - 1), msg[k]});
                else                exp_q.push_back({1'b1, (k == FRAME_LEN - 1), FILL});
            end
            if (msg.size() > FRAME_LEN) mdl_ovr = 1;
        end
    endtask

    function automatic int srcPending();
        int n = 0;
        for (int i = 0; i < N_SRC; i++) n += src_q[i].size();
        return n;
    endfunction

    task automatic runUntilIdle(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || srcPending() > 0) && n < budget) begin
            applyStimulus();
            n++;
        end
        applyStimulus();
        checkOutput({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic drainCredits();
        int n = 0;
        done_en  = 1;
        done_pct = 30;
        while (out_cnt > 0 && n < 1000) begin
            applyStimulus();
            n++;
        end
        done_en = 0;
    endtask

    task automatic resetModel();
        for (int i = 0; i < N_SRC; i++) begin
            src_q[i].delete();
            mdl_q[i].delete();
            started[i] = 0;
        end
        exp_q.delete();
        exp_src_q.delete();
        exp_ovr_q.delete();
        mdl_rr  = 0;
        mdl_ovr = 0;
        out_cnt = 0;
    endtask

    // Scoreboard monitor: pops one expected byte per RS-side handshake
    initial begin
        logic [9:0] e;
        int         s;
        bit         o;
        forever begin
            @(negedge clk);
            #(HALF - 2);
            if (rst) begin
                mon_pos = 0;
            end else if (m_axis_valid && m_axis_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_byte", int'(m_axis_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    if (mon_pos == 0) begin
                        s = exp_src_q.pop_front();
                        o = exp_ovr_q.pop_front();
                        checkOutput("grant_id", int'(grant_id), s);
                        checkOutput("overrun_at_frame_start", int'(overrun), int'(o));
                        frames_started++;
                        out_cnt++;
                        checkOutput("credit_limit", int'(out_cnt <= MAX_INFLIGHT), 1);
                    end
                    checkOutput("m_data", int'(m_axis_data), int'(e[7:0]));
                    checkOutput("m_last", int'(m_axis_last), int'(e[8]));
                    if (e[9]) checkOutput("s_ready_in_pad", int'(s_axis_ready), 0);
                    mon_pos = (mon_pos == FRAME_LEN - 1) ? 0 : mon_pos + 1;
                end
            end
        end
    end

    // Hard stop if something wedges beyond every per-phase budget
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    // Phase sequencer
    initial begin
        int base;
        int n;
        rst          = 1'b1;
        s_axis_valid = '0;
        s_axis_data  = '0;
        s_axis_last  = '0;
        m_axis_ready = 1'b0;
        frame_done   = 1'b0;

        rst_drv = 1;
        repeat (3) applyStimulus();
        checkOutput("rst_m_valid", int'(m_axis_valid), 0);
        checkOutput("rst_s_ready", int'(s_axis_ready), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_grant_id", int'(grant_id), 0);
        checkOutput("rst_overrun", int'(overrun), 0);
        rst_drv = 0;
        applyStimulus();
        checkOutput("idle_busy", int'(busy), 0);

        // Round-robin order 0,1,3,0 with MAX_INFLIGHT=2 and no completions
        $display("[TB] phase: credits and round-robin");
        loadMsg(0, FRAME_LEN, 0);
        loadMsg(1, FRAME_LEN, 0);
        loadMsg(3, FRAME_LEN, 0);
        loadMsg(0, FRAME_LEN, 0);
        commitBatch();
        base = frames_started;
        n = 0;
        while (exp_q.size() > 2 * FRAME_LEN && n < 2000) begin applyStimulus(); n++; end
        repeat (20) applyStimulus();
        checkOutput("withheld_frames", frames_started - base, 2);
        checkOutput("withheld_busy", int'(busy), 0);
        force_done = 1;
        applyStimulus();
        force_done = 0;
        applyStimulus();
        checkOutput("grant_not_same_cycle", int'(busy), 0);
        applyStimulus();
        checkOutput("grant_after_done", int'(busy), 1);
        n = 0;
        while (exp_q.size() > FRAME_LEN && n < 2000) begin applyStimulus(); n++; end
        repeat (10) applyStimulus();
        checkOutput("withheld_again", frames_started - base, 3);
        force_done = 1;
        applyStimulus();
        applyStimulus();
        force_done = 0;
        runUntilIdle("rr", 2000);
        checkOutput("rr_frames", frames_started - base, 4);

        // Latency: IDLE grant cycle then byte 0 on the following cycle
        $display("[TB] phase: single full-length frame");
        loadMsg(0, FRAME_LEN, 0);
        commitBatch();
        applyStimulus();
        checkOutput("lat_grant_cycle_m_valid", int'(m_axis_valid), 0);
        applyStimulus();
        checkOutput("lat_first_byte_m_valid", int'(m_axis_valid), 1);
        runUntilIdle("single", 2000);
        drainCredits();

        // Short message padded with fill bytes
        $display("[TB] phase: padding");
        mready_pct = 60;
        done_en    = 1;
        done_pct   = 5;
        loadMsg(2, 5, 1);
        commitBatch();
        runUntilIdle("pad", 3000);
        mready_pct = 100;
        drainCredits();

        // Oversize message: truncated, sticky overrun, tail drained, next source follows
        $display("[TB] phase: overrun");
        checkOutput("overrun_before", int'(overrun), 0);
        done_en  = 1;
        done_pct = 5;
        loadMsg(1, 230, 0);
        loadMsg(2, 10, 0);
        commitBatch();
        runUntilIdle("overrun", 3000);
        checkOutput("overrun_sticky", int'(overrun), 1);
        drainCredits();

        // Reset in the middle of the second frame while both credits are taken
        $display("[TB] phase: reset mid-frame");
        loadMsg(0, FRAME_LEN, 0);
        loadMsg(1, FRAME_LEN, 0);
        commitBatch();
        base = frames_started;
        n = 0;
        while (!((frames_started - base == 2) && (mon_pos == 100)) && n < 2000) begin
            applyStimulus();
            n++;
        end
        checkOutput("reach_byte_100", mon_pos, 100);
        rst_drv = 1;
        applyStimulus();
        checkOutput("midrst_m_valid", int'(m_axis_valid), 0);
        checkOutput("midrst_m_last", int'(m_axis_last), 0);
        checkOutput("midrst_s_ready", int'(s_axis_ready), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_grant_id", int'(grant_id), 0);
        checkOutput("midrst_overrun", int'(overrun), 0);
        resetModel();
        applyStimulus();
        rst_drv = 0;
        applyStimulus();
        checkOutput("post_rst_busy", int'(busy), 0);
        base = frames_started;
        loadMsg(0, FRAME_LEN, 0);
        loadMsg(2, FRAME_LEN, 0);
        commitBatch();
        runUntilIdle("after_reset", 2000);
        checkOutput("after_reset_frames", frames_started - base, 2);
        drainCredits();

        // Randomised traffic: lengths, sources, stalls on both sides, completion timing
        $display("[TB] phase: random traffic");
        gap_pct    = 30;
        mready_pct = 70;
        done_en    = 1;
        done_pct   = 8;
        for (int k = 0; k < 16; k++) begin
            loadMsg($urandom_range(N_SRC - 1), $urandom_range(235, 1), 0);
        end
        commitBatch();
        runUntilIdle("random", 40000);
        checkOutput("overrun_final", int'(overrun), int'(mdl_ovr));
        done_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
